// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage MIPS pipeline, between the EX/MEM register and
// MEM_WB. LW/SW go through a request/acknowledge data-memory port. The stage
// drops in_ready while an access is outstanding, which stalls upstream.
// Non-memory instructions pass through with one cycle of latency.
//
// Ports
//   clk, resetn              rising-edge clock, async active-low reset
//   in_valid/in_ready        handshake with EX/MEM (in_ready combinational)
//   in_PC, in_IR             instruction PC and word
//   in_ALUoutput             ALU result, also the effective address for LW/SW
//   in_B, in_MOVZ_cond       store data (rt) and MOVZ condition from EX
//   dmem_req/we/addr/wdata   registered data-memory request
//   dmem_ack, dmem_rdata     memory completion and load data
//   o_PC, o_LMD, o_ALUoutput, o_IR, o_MOVZ_cond
//                            registered results to MEM_WB (all zero = bubble)
//   addr_err                 one-cycle pulse: misaligned LW/SW dropped
//   bus_err                  one-cycle pulse: access aborted by timeout
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] in_PC,
    input  logic [31:0] in_IR,
    input  logic [31:0] in_ALUoutput,
    input  logic [31:0] in_B,
    input  logic        in_MOVZ_cond,
    output logic        in_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] o_PC,
    output logic [31:0] o_LMD,
    output logic [31:0] o_ALUoutput,
    output logic [31:0] o_IR,
    output logic        o_MOVZ_cond,
    output logic        addr_err,
    output logic        bus_err
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    // Abort happens when the counter has reached TIMEOUT-1 without an ack,
    // i.e. on the TIMEOUT-th edge after the request was raised.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [31:0] cap_pc_r;
    logic [31:0] cap_ir_r;
    logic [31:0] cap_alu_r;
    logic        cap_movz_r;
    logic        cap_lw_r;

    logic        is_lw_s;
    logic        is_sw_s;
    logic        is_mem_s;
    logic        misaligned_s;

    assign is_lw_s      = (in_IR[31:26] == OP_LW);
    assign is_sw_s      = (in_IR[31:26] == OP_SW);
    assign is_mem_s     = is_lw_s | is_sw_s;
    assign misaligned_s = (in_ALUoutput[1:0] != 2'b00);

    assign in_ready = (state_r == IDLE);

    // Stage FSM: request issue, ack/timeout tracking and the MEM_WB outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            cap_pc_r    <= 32'd0;
            cap_ir_r    <= 32'd0;
            cap_alu_r   <= 32'd0;
            cap_movz_r  <= 1'b0;
            cap_lw_r    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_wdata  <= 32'd0;
            o_PC        <= 32'd0;
            o_LMD       <= 32'd0;
            o_ALUoutput <= 32'd0;
            o_IR        <= 32'd0;
            o_MOVZ_cond <= 1'b0;
            addr_err    <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            // Default every cycle: emit a bubble, error pulses fall back to 0.
            o_PC        <= 32'd0;
            o_LMD       <= 32'd0;
            o_ALUoutput <= 32'd0;
            o_IR        <= 32'd0;
            o_MOVZ_cond <= 1'b0;
            addr_err    <= 1'b0;
            bus_err     <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (in_valid && !is_mem_s) begin
                        o_PC        <= in_PC;
                        o_ALUoutput <= in_ALUoutput;
                        o_IR        <= in_IR;
                        o_MOVZ_cond <= in_MOVZ_cond;
                    end else if (in_valid && misaligned_s) begin
                        addr_err <= 1'b1;
                    end else if (in_valid) begin
                        cap_pc_r   <= in_PC;
                        cap_ir_r   <= in_IR;
                        cap_alu_r  <= in_ALUoutput;
                        cap_movz_r <= in_MOVZ_cond;
                        cap_lw_r   <= is_lw_s;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_sw_s;
                        dmem_addr  <= in_ALUoutput;
                        dmem_wdata <= is_sw_s ? in_B : 32'd0;
                        cnt_r      <= 8'd0;
                        state_r    <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // Ack is checked first so it wins over a same-edge timeout.
                    if (dmem_ack) begin
                        o_PC        <= cap_pc_r;
                        o_ALUoutput <= cap_alu_r;
                        o_IR        <= cap_ir_r;
                        o_MOVZ_cond <= cap_movz_r;
                        o_LMD       <= cap_lw_r ? dmem_rdata : 32'd0;
                        dmem_req    <= 1'b0;
                        state_r     <= IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        dmem_req <= 1'b0;
                        bus_err  <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [31:0] in_PC, in_IR, in_ALUoutput, in_B;
    logic        in_MOVZ_cond;
    logic        in_ready;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] o_PC, o_LMD, o_ALUoutput, o_IR;
    logic        o_MOVZ_cond;
    logic        addr_err, bus_err;

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_PC(in_PC), .in_IR(in_IR),
        .in_ALUoutput(in_ALUoutput), .in_B(in_B), .in_MOVZ_cond(in_MOVZ_cond),
        .in_ready(in_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .o_PC(o_PC), .o_LMD(o_LMD), .o_ALUoutput(o_ALUoutput), .o_IR(o_IR),
        .o_MOVZ_cond(o_MOVZ_cond), .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // cycle counter: advanced by each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = instruction result, 1 = addr_err pulse, 2 = bus_err pulse
    typedef struct {
        int          kind;
        logic [31:0] pc, ir, alu, lmd;
        logic        movz;
        int          at;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          lat;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        else return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Offer one instruction upstream; lat = edges after the request edge at
    // which memory acks (lat > TO means the access times out).
    task automatic issue(input logic [31:0] pc, input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] b, input logic movz, input int lat);
        exp_t e;
        req_t r;
        int waited;
        logic [5:0] op;
        bit lw, sw;
        in_PC = pc; in_IR = ir; in_ALUoutput = alu; in_B = b; in_MOVZ_cond = movz;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < TO + 8) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_wait: got in_ready 0 want 1 within %0d cycles", TO + 8);
            in_valid = 1'b0;
            return;
        end
        op = ir[31:26];
        lw = (op == 6'b100011);
        sw = (op == 6'b101011);
        e.kind = 0; e.pc = 32'd0; e.ir = 32'd0; e.alu = 32'd0; e.lmd = 32'd0;
        e.movz = 1'b0; e.at = cyc + 1;
        if (!(lw || sw)) begin
            e.pc = pc; e.ir = ir; e.alu = alu; e.movz = movz;
        end else if (alu[1:0] != 2'b00) begin
            e.kind = 1;
        end else begin
            r.addr = alu; r.we = sw; r.wdata = sw ? b : 32'd0; r.lat = lat;
            req_q.push_back(r);
            if (lat <= TO) begin
                e.pc = pc; e.ir = ir; e.alu = alu; e.movz = movz;
                e.lmd = lw ? mem_rd(alu) : 32'd0;
                if (sw) mem[alu] = b;
                e.at = e.at + lat;
            end else begin
                e.kind = 2;
                e.at = e.at + TO;
            end
        end
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        if (!(lw || sw) || alu[1:0] != 2'b00) begin
            chk32("stay_idle_ready", 32'(in_ready), 32'd1);
            chk32("no_req", 32'(dmem_req), 32'd0);
        end
    endtask

    // Monitor: pops the scoreboard whenever the stage presents a result or
    // an error pulse; otherwise the outputs must be a clean bubble.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (addr_err || bus_err || o_IR != 32'd0) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got IR %h addr_err %b bus_err %b want nothing",
                             o_IR, addr_err, bus_err);
                end else begin
                    e = exp_q.pop_front();
                    chk32("out_cycle", 32'(cyc), 32'(e.at));
                    chk32("addr_err", 32'(addr_err), 32'(e.kind == 1));
                    chk32("bus_err", 32'(bus_err), 32'(e.kind == 2));
                    chk32("o_PC", o_PC, e.pc);
                    chk32("o_IR", o_IR, e.ir);
                    chk32("o_ALUoutput", o_ALUoutput, e.alu);
                    chk32("o_LMD", o_LMD, e.lmd);
                    chk32("o_MOVZ_cond", 32'(o_MOVZ_cond), 32'(e.movz));
                end
            end else begin
                checks++;
                if ({o_PC, o_LMD, o_ALUoutput} != '0 || o_MOVZ_cond) begin
                    errors++;
                    $display("FAIL bubble: got PC %h LMD %h ALU %h MOVZ %b want all zero",
                             o_PC, o_LMD, o_ALUoutput, o_MOVZ_cond);
                end
            end
        end
    end

    // Memory responder: checks each request, acks after the chosen latency,
    // and pokes spurious acks while idle (they must be ignored).
    initial begin
        req_t r;
        int k;
        bit busy;
        busy = 1'b0;
        k = 0;
        r.addr = 32'd0; r.we = 1'b0; r.wdata = 32'd0; r.lat = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (busy) begin
                if (k == r.lat || k == TO) begin
                    chk32("req_drop", 32'(dmem_req), 32'd0);
                    chk32("ready_after_done", 32'(in_ready), 32'd1);
                    busy = 1'b0;
                end else begin
                    chk32("req_hold", 32'(dmem_req), 32'd1);
                    chk32("ready_low", 32'(in_ready), 32'd0);
                    chk32("addr_hold", dmem_addr, r.addr);
                end
            end else if (dmem_req) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr %h want no request", dmem_addr);
                end else begin
                    r = req_q.pop_front();
                    chk32("dmem_addr", dmem_addr, r.addr);
                    chk32("dmem_we", 32'(dmem_we), 32'(r.we));
                    chk32("dmem_wdata", dmem_wdata, r.wdata);
                    chk32("ready_in_access", 32'(in_ready), 32'd0);
                    busy = 1'b1;
                    k = 0;
                end
            end
            if (busy) begin
                k++;
                dmem_ack = (k == r.lat);
                dmem_rdata = (k == r.lat && !r.we) ? mem_rd(r.addr) : $urandom;
            end else begin
                dmem_ack = ($urandom_range(0, 7) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    initial begin
        logic [31:0] ir, alu, b;
        logic [5:0]  op;
        int sel, lat, rr, drain;
        resetn = 1'b0; in_valid = 1'b0; in_PC = 32'd0; in_IR = 32'd0;
        in_ALUoutput = 32'd0; in_B = 32'd0; in_MOVZ_cond = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk32("rst_ready", 32'(in_ready), 32'd1);
        chk32("rst_req", 32'(dmem_req), 32'd0);
        chk32("rst_o_IR", o_IR, 32'd0);
        chk32("rst_errs", 32'({addr_err, bus_err}), 32'd0);

        // Reset mid-cycle while an LW is outstanding.
        in_PC = 32'h4; in_IR = 32'h8C880004; in_ALUoutput = 32'h40; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk32("pre_rst_req", 32'(dmem_req), 32'd1);
        chk32("pre_rst_ready", 32'(in_ready), 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk32("async_rst_req", 32'(dmem_req), 32'd0);
        chk32("async_rst_ready", 32'(in_ready), 32'd1);
        chk32("async_rst_outs", o_PC | o_LMD | o_ALUoutput | o_IR, 32'd0);
        chk32("async_rst_errs", 32'({addr_err, bus_err, o_MOVZ_cond}), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        mem[32'h100] = 32'hDEADBEEF;
        mon_en = 1'b1;
        issue(32'h10, 32'h012A4020, 32'h55,   32'h0,        1'b0, 1);
        issue(32'h14, 32'h8C880004, 32'h100,  32'h0,        1'b1, 3);
        issue(32'h18, 32'hAC880008, 32'h200,  32'hCAFEF00D, 1'b0, 1);
        issue(32'h1C, 32'h012A4020, 32'h66,   32'h0,        1'b1, 1);
        issue(32'h20, 32'h8C880004, 32'h104,  32'h0,        1'b0, TO + 1);
        issue(32'h24, 32'h8C880004, 32'h108,  32'h0,        1'b1, TO);
        issue(32'h28, 32'h8C880004, 32'h1002, 32'h0,        1'b0, 1);
        issue(32'h2C, 32'hAC880008, 32'h10C,  32'h12345678, 1'b0, 2);
        issue(32'h30, 32'h8C880004, 32'h10C,  32'h0,        1'b1, 1);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            b = $urandom;
            if (sel < 4) begin
                ir = $urandom;
                op = ir[31:26];
                while (ir == 32'd0 || op == 6'b100011 || op == 6'b101011) begin
                    ir = $urandom;
                    op = ir[31:26];
                end
                alu = $urandom;
            end else begin
                op = (sel < 7) ? 6'b100011 : 6'b101011;
                ir = {op, 26'($urandom)};
                alu = 32'($urandom_range(0, 63)) << 2;
                if (sel == 9) alu = alu | 32'($urandom_range(1, 3));
            end
            rr = $urandom_range(0, 9);
            if (rr < 6)      lat = $urandom_range(1, 4);
            else if (rr < 8) lat = $urandom_range(5, TO);
            else             lat = TO + $urandom_range(0, 2);
            issue(32'h1000 + 32'(i) * 32'd4, ir, alu, b, 1'($urandom), lat);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        end

        drain = 0;
        while (exp_q.size() != 0 && drain < 4 * TO) begin
            @(negedge clk);
            drain++;
        end
        repeat (3) @(negedge clk);
        chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk32("req_queue_empty", 32'(req_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
